// File: rtl/aes_uart_frame_sequencer.sv
// Frame sequencer between UART RX/TX and the AES core: collects one 128-bit
// block (optional decrypt marker first), starts AES, then streams the result out.
module aes_uart_frame_sequencer #(
   parameter int          BLOCK_BYTES  = 16,
   parameter logic [7:0]  MODE_MARKER  = 8'hFF,
   parameter int          IDLE_TIMEOUT = 8680
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_rx_valid,
   input  logic [7:0]   i_rx_byte,
   output logic         o_aes_start,
   output logic         o_aes_decrypt,
   output logic [127:0] o_aes_in,
   input  logic         i_aes_done,
   input  logic [127:0] i_aes_out,
   output logic         o_tx_start,
   output logic [7:0]   o_tx_byte,
   input  logic         i_tx_busy,
   output logic         o_done,
   output logic         o_frame_err,
   output logic         o_rx_drop
);

   localparam int CW = $clog2(BLOCK_BYTES + 1);
   localparam int SW = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_START, S_WAIT_AES, S_TX_SEND, S_TX_GAP, S_FLUSH
   } state_t;

   state_t         r_state, w_next;
   logic [CW-1:0]  r_cnt, r_idx;
   logic [SW-1:0]  r_sil;
   logic [127:0]   r_sreg, r_aes_in;
   logic           r_dec;

   logic w_is_marker, w_last_byte, w_timeout;

   assign w_is_marker = (i_rx_byte == MODE_MARKER);
   assign w_last_byte = (r_cnt == CW'(BLOCK_BYTES - 1));
   // A byte arriving in the timeout cycle takes priority over the abort.
   assign w_timeout   = !i_rx_valid && (r_sil == SW'(IDLE_TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_aes_start = 1'b0;
      o_tx_start  = 1'b0;
      o_done      = 1'b0;
      o_frame_err = 1'b0;
      o_rx_drop   = 1'b0;
      case (r_state)
         S_IDLE:     if (i_rx_valid) w_next = S_COLLECT;
         S_COLLECT: begin
            if (i_rx_valid) begin
               if (w_last_byte) w_next = S_START;
            end else if (w_timeout) begin
               o_frame_err = 1'b1;
               w_next      = S_IDLE;
            end
         end
         S_START: begin
            o_aes_start = 1'b1;
            w_next      = S_WAIT_AES;
         end
         S_WAIT_AES: if (i_aes_done) w_next = S_TX_SEND;
         S_TX_SEND: begin
            if (!i_tx_busy) begin
               o_tx_start = 1'b1;
               w_next     = S_TX_GAP;
            end
         end
         // Gives the transmitter a cycle to raise busy before it is sampled.
         S_TX_GAP:   w_next = (r_idx < CW'(BLOCK_BYTES)) ? S_TX_SEND : S_FLUSH;
         S_FLUSH: begin
            if (!i_tx_busy) begin
               o_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         default:    w_next = S_IDLE;
      endcase
      if (i_rx_valid && (r_state != S_IDLE) && (r_state != S_COLLECT))
         o_rx_drop = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_idx    <= '0;
         r_sil    <= '0;
         r_sreg   <= '0;
         r_aes_in <= '0;
         r_dec    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_rx_valid) begin
                  r_sil <= '0;
                  r_dec <= w_is_marker;
                  if (w_is_marker) begin
                     r_cnt <= '0;
                  end else begin
                     r_cnt    <= CW'(1);
                     r_aes_in <= {r_aes_in[119:0], i_rx_byte};
                  end
               end
            end
            S_COLLECT: begin
               if (i_rx_valid) begin
                  r_aes_in <= {r_aes_in[119:0], i_rx_byte};
                  r_cnt    <= r_cnt + CW'(1);
                  r_sil    <= '0;
               end else if (w_timeout) begin
                  r_cnt <= '0;
                  r_sil <= '0;
               end else begin
                  r_sil <= r_sil + SW'(1);
               end
            end
            S_WAIT_AES: begin
               if (i_aes_done) begin
                  r_sreg <= i_aes_out;
                  r_idx  <= '0;
               end
            end
            S_TX_SEND: begin
               if (!i_tx_busy) begin
                  r_sreg <= {r_sreg[119:0], 8'h00};
                  r_idx  <= r_idx + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_aes_in      = r_aes_in;
   assign o_aes_decrypt = r_dec;
   assign o_tx_byte     = r_sreg[127:120];

endmodule

// File: tb/tb_aes_uart_frame_sequencer.sv
// Scoreboard bench for aes_uart_frame_sequencer with behavioural AES and UART TX models.
module tb_aes_uart_frame_sequencer;
   localparam int T = 8680;

   logic         clk = 1'b0, rst_n = 1'b1;
   logic         rx_valid = 1'b0;
   logic [7:0]   rx_byte = '0;
   logic         aes_start, aes_dec;
   logic [127:0] aes_in;
   logic         aes_done = 1'b0;
   logic [127:0] aes_out = '0;
   logic         tx_start;
   logic [7:0]   tx_byte;
   logic         tx_busy = 1'b0;
   logic         done, ferr, drop;

   aes_uart_frame_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
      .o_aes_start(aes_start), .o_aes_decrypt(aes_dec), .o_aes_in(aes_in),
      .i_aes_done(aes_done), .i_aes_out(aes_out),
      .o_tx_start(tx_start), .o_tx_byte(tx_byte), .i_tx_busy(tx_busy),
      .o_done(done), .o_frame_err(ferr), .o_rx_drop(drop)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic dec; logic [127:0] data; } aes_req_t;

   int       checks = 0, errors = 0;
   aes_req_t exp_aes[$];
   logic [7:0] exp_tx[$];
   int       exp_done = 0, exp_ferr = 0, exp_drop = 0, tx_seen = 0;
   aes_req_t last_req = '0;
   logic     real_done = 1'b0;
   bit       first_aes = 1'b1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1; rx_byte = b;
      tick();
      rx_valid = 1'b0;
   endtask

   // Monitor: every DUT strobe is matched against what the stimulus predicted.
   initial forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (aes_start) begin
         chk("aes_start_expected", exp_aes.size() > 0, 1);
         if (exp_aes.size() > 0) begin
            last_req = exp_aes.pop_front();
            chk("aes_decrypt", aes_dec, last_req.dec);
            chk("aes_in", aes_in, last_req.data);
         end
      end
      if (real_done) begin
         chk("aes_decrypt_stable", aes_dec, last_req.dec);
         chk("aes_in_stable", aes_in, last_req.data);
      end
      if (tx_start) begin
         tx_seen++;
         chk("tx_start_while_busy", tx_busy, 0);
         chk("tx_start_expected", exp_tx.size() > 0, 1);
         if (exp_tx.size() > 0) chk("tx_byte", tx_byte, exp_tx.pop_front());
      end
      if (done) begin
         chk("done_while_busy", tx_busy, 0);
         chk("done_bytes_left", exp_tx.size(), 0);
         chk("done_expected", exp_done > 0, 1);
         chk("aes_in_hold", aes_in, last_req.data);
         if (exp_done > 0) exp_done--;
      end
      if (ferr) begin
         chk("frame_err_expected", exp_ferr > 0, 1);
         if (exp_ferr > 0) exp_ferr--;
      end
      if (drop) begin
         chk("rx_drop_expected", exp_drop > 0, 1);
         if (exp_drop > 0) exp_drop--;
      end
   end

   // AES model: result after a latency, then one stray done pulse that must be ignored.
   initial forever begin
      @(negedge clk);
      if (rst_n && aes_start) begin
         int lat;
         logic [127:0] res;
         lat = first_aes ? 10 : int'($urandom_range(1, 15));
         res = first_aes ? 128'h00112233445566778899AABBCCDDEEFF
                         : {$urandom, $urandom, $urandom, $urandom};
         first_aes = 1'b0;
         repeat (lat) tick();
         aes_out = res; aes_done = 1'b1; real_done = 1'b1;
         for (int i = 0; i < 16; i++) exp_tx.push_back(res[127-8*i -: 8]);
         tick();
         aes_done = 1'b0; real_done = 1'b0;
         repeat (30) tick();
         aes_out = {$urandom, $urandom, $urandom, $urandom}; aes_done = 1'b1;
         tick();
         aes_done = 1'b0;
      end
   end

   // UART TX model: busy for 20 cycles starting the cycle after tx_start.
   initial forever begin
      @(negedge clk);
      if (tx_start) begin
         tick();
         tx_busy = 1'b1;
         repeat (20) tick();
         tx_busy = 1'b0;
      end
   end

   task automatic send_frame(input bit dec, input logic [127:0] data, input int maxgap,
                             input int ndrop, input int long_gap_after, input bit wait_end);
      aes_req_t r;
      int n;
      r.dec = dec; r.data = data;
      exp_aes.push_back(r);
      exp_done++;
      if (dec) begin
         send(8'hFF);
         repeat ($urandom_range(0, maxgap)) tick();
      end
      for (int i = 0; i < 16; i++) begin
         send(data[127-8*i -: 8]);
         if (i == 15) break;
         if (i == long_gap_after) repeat (T - 1) tick();
         else repeat ($urandom_range(0, maxgap)) tick();
      end
      for (int d = 0; d < ndrop; d++) begin
         exp_drop++;
         send(8'($urandom));
         repeat ($urandom_range(0, 3)) tick();
      end
      if (wait_end) begin
         n = 0;
         while (exp_done > 0 && n < 3000) begin tick(); n++; end
         chk("frame_complete", exp_done, 0);
         chk("tx_all_sent", exp_tx.size(), 0);
         chk("drops_seen", exp_drop, 0);
      end
   endtask

   task automatic partial(input bit dec, input int k);
      if (dec) send(8'hFF);
      for (int i = 0; i < k; i++) send((i == 0 && !dec) ? 8'h5A : 8'($urandom));
      exp_ferr++;
      for (int kk = 1; kk <= T; kk++) begin
         if (kk >= T - 1) begin
            @(negedge clk);
            chk("frame_err_timing", ferr, kk == T);
         end
         tick();
      end
      chk("frame_err_seen", exp_ferr, 0);
   endtask

   function automatic logic [127:0] rand_block(input bit dec);
      logic [127:0] v;
      v = {$urandom, $urandom, $urandom, $urandom};
      if (!dec && v[127:120] == 8'hFF) v[127:120] = 8'h3C;
      return v;
   endfunction

   initial begin
      int n, base;
      bit d;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_strobes", {aes_start, tx_start, done, ferr, drop}, 0);
      chk("rst_aes_in", aes_in, 0);
      chk("rst_dec_txbyte", {aes_dec, tx_byte}, 0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      send_frame(1'b0, 128'h00FF00007A9B9B9B86D2D27A7A7B7A86, 3, 0, -1, 1'b1);
      send_frame(1'b1, 128'h7ADDDD937A7B7A7A7A93937A7D7B7B7A, 2, 3, -1, 1'b1);
      partial(1'b0, 5);
      send_frame(1'b0, 128'h00FF00007A9B9B9B86D2D27A7A7B7A86, 0, 0, -1, 1'b1);
      send_frame(1'b0, rand_block(1'b0), 2, 1, 7, 1'b1);
      partial(1'b1, 3);
      for (int f = 0; f < 8; f++) begin
         d = 1'($urandom_range(0, 1));
         send_frame(d, rand_block(d), 4, int'($urandom_range(0, 3)), -1, 1'b1);
      end

      // Reset in the middle of transmission.
      base = tx_seen;
      send_frame(1'b0, rand_block(1'b0), 1, 0, -1, 1'b0);
      n = 0;
      while (tx_seen < base + 3 && n < 3000) begin tick(); n++; end
      chk("third_tx_reached", tx_seen >= base + 3, 1);
      rst_n = 1'b0;
      exp_tx.delete(); exp_aes.delete(); exp_done = 0;
      @(negedge clk);
      chk("midrst_strobes", {aes_start, tx_start, done, ferr, drop}, 0);
      chk("midrst_aes_in", aes_in, 0);
      chk("midrst_dec_txbyte", {aes_dec, tx_byte}, 0);
      tick(); tick();
      rst_n = 1'b1;
      base = tx_seen;
      repeat (400) tick();
      chk("no_tx_after_reset", tx_seen, base);
      send_frame(1'b1, rand_block(1'b1), 2, 1, -1, 1'b1);

      chk("final_aes_queue", exp_aes.size(), 0);
      chk("final_ferr", exp_ferr, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
